// File: rtl/countdown_round_sequencer_pkg.sv
// Shared types and constants for the countdown round sequencer.
// Holds the FSM state enum, the winner encoding, the score width and a
// saturating score increment helper.
package countdown_round_sequencer_pkg;

  localparam int unsigned SCORE_W  = 4;
  localparam int unsigned WINNER_W = 2;
  localparam int unsigned ROUND_W  = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    WAIT_TIMER = 3'd2,
    RESPOND    = 3'd3,
    SCORE      = 3'd4,
    DONE       = 3'd5,
    ERROR      = 3'd6
  } state_t;

  localparam logic [WINNER_W-1:0] WIN_NONE  = 2'd0;
  localparam logic [WINNER_W-1:0] WIN_A     = 2'd1;
  localparam logic [WINNER_W-1:0] WIN_B     = 2'd2;
  localparam logic [WINNER_W-1:0] WIN_FOUL2 = 2'd3;

  // Score +1, sticking at all-ones.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/countdown_round_sequencer_press_arbiter.sv
// Button press detection and same-cycle tie resolution.
// Ports:
//   clk, rst        clock, async active-high reset
//   btn_a, btn_b    synchronized button levels
//   take_tie        the FSM consumed a tie this cycle; flip priority
//   press_a_c/_b_c  rising edge of each button (combinational)
//   tie_c           both buttons rose this cycle (combinational)
//   first_winner_c  response-window winner for this cycle's presses
module countdown_round_sequencer_press_arbiter
  import countdown_round_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_a,
  input  logic                btn_b,
  input  logic                take_tie,
  output logic                press_a_c,
  output logic                press_b_c,
  output logic                tie_c,
  output logic [WINNER_W-1:0] first_winner_c
);

  logic prev_a;
  logic prev_b;
  logic prio_b;  // 0: A wins the next tie, 1: B wins it

  // Previous button levels and round-robin tie priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_a <= 1'b0;
      prev_b <= 1'b0;
      prio_b <= 1'b0;
    end else begin
      prev_a <= btn_a;
      prev_b <= btn_b;
      if (take_tie) prio_b <= ~prio_b;
    end
  end

  assign press_a_c = btn_a & ~prev_a;
  assign press_b_c = btn_b & ~prev_b;
  assign tie_c     = press_a_c & press_b_c;

  // Winner as seen from the response window.
  always_comb begin
    first_winner_c = WIN_NONE;
    if (tie_c)          first_winner_c = prio_b ? WIN_B : WIN_A;
    else if (press_a_c) first_winner_c = WIN_A;
    else if (press_b_c) first_winner_c = WIN_B;
  end

endmodule

// File: rtl/countdown_round_sequencer.sv
// Game-round controller: launches the countdown timer, waits for its done
// pulse, runs a timed response window, scores each round and reports game
// over after NUM_ROUNDS rounds.
// Ports:
//   Clk100M, Reset          clock, async active-high reset
//   go, abort               start a new game / return to IDLE
//   btnA, btnB              synchronized player buttons (level)
//   timerDone               one-cycle done pulse from the countdown timer
//   timerStart              one-cycle start pulse to the countdown timer
//   roundActive, roundNum   round in progress, 1-based round number
//   winnerValid, winner     round result pulse and held result
//   scoreA, scoreB          saturating scores
//   gameOver, timeoutErr    DONE / ERROR indicators
module countdown_round_sequencer
  import countdown_round_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS      = 3,
  parameter int unsigned RESP_WINDOW_CYC = 100000000,
  parameter int unsigned TIMEOUT_CYC     = 700000000
) (
  input  logic                Clk100M,
  input  logic                Reset,
  input  logic                go,
  input  logic                abort,
  input  logic                btnA,
  input  logic                btnB,
  input  logic                timerDone,
  output logic                timerStart,
  output logic                roundActive,
  output logic [ROUND_W-1:0]  roundNum,
  output logic                winnerValid,
  output logic [WINNER_W-1:0] winner,
  output logic [SCORE_W-1:0]  scoreA,
  output logic [SCORE_W-1:0]  scoreB,
  output logic                gameOver,
  output logic                timeoutErr
);

  localparam int unsigned WIN_CNT_W = (RESP_WINDOW_CYC > 1) ? $clog2(RESP_WINDOW_CYC) : 1;
  localparam int unsigned TO_CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WIN_CNT_W-1:0] WIN_LOAD = WIN_CNT_W'(RESP_WINDOW_CYC - 1);
  localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ROUND_W-1:0]   LAST_RND = ROUND_W'(NUM_ROUNDS);

  state_t state, state_n;
  logic [WIN_CNT_W-1:0] win_cnt, win_cnt_n;
  logic [TO_CNT_W-1:0]  to_cnt, to_cnt_n;
  logic [ROUND_W-1:0]   round_n;
  logic [WINNER_W-1:0]  winner_n;
  logic [SCORE_W-1:0]   score_a_n, score_b_n;

  logic                press_a_c, press_b_c, tie_c, take_tie_c;
  logic [WINNER_W-1:0] first_winner_c;

  countdown_round_sequencer_press_arbiter u_arb (
    .clk            (Clk100M),
    .rst            (Reset),
    .btn_a          (btnA),
    .btn_b          (btnB),
    .take_tie       (take_tie_c),
    .press_a_c      (press_a_c),
    .press_b_c      (press_b_c),
    .tie_c          (tie_c),
    .first_winner_c (first_winner_c)
  );

  // State, counters, scores and registered Moore-style outputs.
  always_ff @(posedge Clk100M or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      win_cnt     <= '0;
      to_cnt      <= '0;
      roundNum    <= '0;
      winner      <= WIN_NONE;
      scoreA      <= '0;
      scoreB      <= '0;
      timerStart  <= 1'b0;
      roundActive <= 1'b0;
      winnerValid <= 1'b0;
      gameOver    <= 1'b0;
      timeoutErr  <= 1'b0;
    end else begin
      state       <= state_n;
      win_cnt     <= win_cnt_n;
      to_cnt      <= to_cnt_n;
      roundNum    <= round_n;
      winner      <= winner_n;
      scoreA      <= score_a_n;
      scoreB      <= score_b_n;
      // Outputs decode the state being entered so they line up with it.
      timerStart  <= (state_n == START);
      roundActive <= (state_n inside {START, WAIT_TIMER, RESPOND});
      winnerValid <= (state_n == SCORE);
      gameOver    <= (state_n == DONE);
      timeoutErr  <= (state_n == ERROR);
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_n    = state;
    win_cnt_n  = win_cnt;
    to_cnt_n   = to_cnt;
    round_n    = roundNum;
    winner_n   = winner;
    score_a_n  = scoreA;
    score_b_n  = scoreB;
    take_tie_c = 1'b0;

    if (abort) begin
      state_n = IDLE;
      round_n = '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (go) begin
            score_a_n = '0;
            score_b_n = '0;
            round_n   = ROUND_W'(1);
            winner_n  = WIN_NONE;
            state_n   = START;
          end
        end
        START: begin
          to_cnt_n = '0;
          state_n  = WAIT_TIMER;
        end
        WAIT_TIMER: begin
          if (timerDone) begin
            win_cnt_n = WIN_LOAD;
            state_n   = RESPOND;
          end else if (press_a_c || press_b_c) begin
            // False start: the other player takes the round.
            if (tie_c)          winner_n = WIN_FOUL2;
            else if (press_a_c) winner_n = WIN_B;
            else                winner_n = WIN_A;
            state_n = SCORE;
          end else if (to_cnt == TO_LAST) begin
            state_n = ERROR;
          end else begin
            to_cnt_n = to_cnt + TO_CNT_W'(1);
          end
        end
        RESPOND: begin
          // A press on the expiry cycle still counts.
          if (press_a_c || press_b_c) begin
            winner_n   = first_winner_c;
            take_tie_c = tie_c;
            state_n    = SCORE;
          end else if (win_cnt == '0) begin
            winner_n = WIN_NONE;
            state_n  = SCORE;
          end else begin
            win_cnt_n = win_cnt - WIN_CNT_W'(1);
          end
        end
        SCORE: begin
          if (roundNum == LAST_RND) begin
            state_n = DONE;
          end else begin
            round_n = roundNum + ROUND_W'(1);
            state_n = START;
          end
        end
        default: state_n = IDLE;
      endcase

      // Scores move together with winner so both are valid during SCORE.
      if (state_n == SCORE) begin
        if (winner_n == WIN_A) score_a_n = sat_inc(scoreA);
        if (winner_n == WIN_B) score_b_n = sat_inc(scoreB);
      end
    end
  end

endmodule

// File: tb/tb_countdown_round_sequencer.sv
// Self-checking bench for countdown_round_sequencer: directed scenarios with
// literal expectations, then randomized traffic, all compared every cycle
// against a behavioural model of the round rules.
module tb_countdown_round_sequencer;

  localparam int NR = 2;
  localparam int RW = 10;
  localparam int TO = 50;

  localparam int P_IDLE  = 0;
  localparam int P_START = 1;
  localparam int P_WAIT  = 2;
  localparam int P_RESP  = 3;
  localparam int P_SCORE = 4;
  localparam int P_DONE  = 5;
  localparam int P_ERR   = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go = 1'b0, abort = 1'b0, btnA = 1'b0, btnB = 1'b0, timerDone = 1'b0;
  logic       timerStart, roundActive, winnerValid, gameOver, timeoutErr;
  logic [3:0] roundNum, scoreA, scoreB;
  logic [1:0] winner;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  countdown_round_sequencer #(
    .NUM_ROUNDS(NR), .RESP_WINDOW_CYC(RW), .TIMEOUT_CYC(TO)
  ) dut (
    .Clk100M(clk), .Reset(rst), .go(go), .abort(abort), .btnA(btnA), .btnB(btnB),
    .timerDone(timerDone), .timerStart(timerStart), .roundActive(roundActive),
    .roundNum(roundNum), .winnerValid(winnerValid), .winner(winner),
    .scoreA(scoreA), .scoreB(scoreB), .gameOver(gameOver), .timeoutErr(timeoutErr)
  );

  // Behavioural model: phase, cycles elapsed in the phase, round, scores.
  typedef struct packed {
    int phase;
    int elapsed;
    int round;
    int win;
    int sa;
    int sb;
    bit prev_a;
    bit prev_b;
    bit prio_b;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t c, input bit g, input bit ab,
                                        input bit a, input bit b, input bit td);
    model_t n = c;
    bit pa = a && !c.prev_a;
    bit pb = b && !c.prev_b;
    if (ab) begin
      n.phase = P_IDLE;
      n.round = 0;
    end else begin
      case (c.phase)
        P_IDLE, P_DONE, P_ERR:
          if (g) begin
            n.phase = P_START; n.round = 1; n.win = 0; n.sa = 0; n.sb = 0;
          end
        P_START: begin
          n.phase = P_WAIT; n.elapsed = 0;
        end
        P_WAIT:
          if (td) begin
            n.phase = P_RESP; n.elapsed = 0;
          end else if (pa || pb) begin
            n.win = (pa && pb) ? 3 : (pa ? 2 : 1);
            n.phase = P_SCORE;
          end else begin
            n.elapsed = c.elapsed + 1;
            if (n.elapsed >= TO) n.phase = P_ERR;
          end
        P_RESP:
          if (pa && pb) begin
            n.win = c.prio_b ? 2 : 1; n.prio_b = !c.prio_b; n.phase = P_SCORE;
          end else if (pa) begin
            n.win = 1; n.phase = P_SCORE;
          end else if (pb) begin
            n.win = 2; n.phase = P_SCORE;
          end else begin
            n.elapsed = c.elapsed + 1;
            if (n.elapsed >= RW) begin
              n.win = 0; n.phase = P_SCORE;
            end
          end
        P_SCORE:
          if (c.round == NR) n.phase = P_DONE;
          else begin
            n.round = c.round + 1; n.phase = P_START;
          end
        default: n.phase = P_IDLE;
      endcase
      if (n.phase == P_SCORE && c.phase != P_SCORE) begin
        if (n.win == 1 && n.sa < 15) n.sa = n.sa + 1;
        if (n.win == 2 && n.sb < 15) n.sb = n.sb + 1;
      end
    end
    n.prev_a = a;
    n.prev_b = b;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_next(m, go, abort, btnA, btnB, timerDone);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_timerStart",  32'(timerStart),  32'(m.phase == P_START));
      chk("m_roundActive", 32'(roundActive),
          32'(m.phase == P_START || m.phase == P_WAIT || m.phase == P_RESP));
      chk("m_winnerValid", 32'(winnerValid), 32'(m.phase == P_SCORE));
      chk("m_gameOver",    32'(gameOver),    32'(m.phase == P_DONE));
      chk("m_timeoutErr",  32'(timeoutErr),  32'(m.phase == P_ERR));
      chk("m_roundNum",    32'(roundNum),    32'(m.round));
      chk("m_winner",      32'(winner),      32'(m.win));
      chk("m_scoreA",      32'(scoreA),      32'(m.sa));
      chk("m_scoreB",      32'(scoreB),      32'(m.sb));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for the START cycle, then pulse timerDone d cycles later.
  task automatic start_done(input string name, input int d);
    for (int i = 0; i < 20; i++) begin
      if (timerStart) break;
      cyc(1);
    end
    chk({name, "_start"}, 32'(timerStart), 32'd1);
    cyc(d);
    timerDone = 1'b1;
    cyc(1);
    timerDone = 1'b0;
  endtask

  task automatic press(input logic a, input logic b);
    btnA = a;
    btnB = b;
    cyc(1);
    btnA = 1'b0;
    btnB = 1'b0;
  endtask

  task automatic chk_score(input string name, input int w, input int sa, input int sb);
    chk({name, "_wv"}, 32'(winnerValid), 32'd1);
    chk({name, "_w"},  32'(winner), 32'(w));
    chk({name, "_sa"}, 32'(scoreA), 32'(sa));
    chk({name, "_sb"}, 32'(scoreB), 32'(sb));
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {21'd0, timerStart, roundActive, roundNum, winnerValid, winner,
               gameOver, timeoutErr}, 32'd0);
    chk({name, "_scores"}, {24'd0, scoreA, scoreB}, 32'd0);
  endtask

  initial begin
    int td;
    cyc(3);
    chk_all_zero("reset");
    rst = 1'b0;
    cmp_en = 1'b1;

    // Nominal game.
    go = 1'b1; cyc(1); go = 1'b0;
    chk("go_latency", 32'(timerStart), 32'd1);
    chk("go_round", 32'(roundNum), 32'd1);
    start_done("nom1", 5);
    chk("nom1_respond", 32'(roundActive), 32'd1);
    cyc(2);
    press(1'b1, 1'b0);
    chk_score("nom1", 1, 1, 0);
    start_done("nom2", 5);
    press(1'b0, 1'b1);
    chk_score("nom2", 2, 1, 1);
    cyc(1);
    chk("nom_gameover", 32'(gameOver), 32'd1);
    chk("nom_round", 32'(roundNum), 32'd2);

    // False starts.
    go = 1'b1; cyc(1); go = 1'b0;
    cyc(1);
    press(1'b0, 1'b1);
    chk_score("fs_b", 1, 1, 0);
    cyc(2);
    press(1'b1, 1'b1);
    chk_score("fs_both", 3, 1, 0);
    cyc(1);

    // Ties in the response window, priority alternates.
    go = 1'b1; cyc(1); go = 1'b0;
    start_done("tie1", 3);
    press(1'b1, 1'b1);
    chk_score("tie1", 1, 1, 0);
    start_done("tie2", 2);
    press(1'b1, 1'b1);
    chk_score("tie2", 2, 1, 1);
    cyc(1);

    // Window expiry, then a press on the last window cycle.
    go = 1'b1; cyc(1); go = 1'b0;
    start_done("win1", 2);
    cyc(9);
    chk("win_open_last", 32'(winnerValid), 32'd0);
    cyc(1);
    chk_score("win_expire", 0, 0, 0);
    start_done("win2", 2);
    cyc(9);
    press(1'b1, 1'b0);
    chk_score("win_lastpress", 1, 1, 0);
    cyc(1);

    // Timeout waiting for timerDone.
    go = 1'b1; cyc(1); go = 1'b0;
    cyc(1);
    cyc(49);
    chk("to_before", 32'(timeoutErr), 32'd0);
    cyc(1);
    chk("to_err", 32'(timeoutErr), 32'd1);
    chk("to_active", 32'(roundActive), 32'd0);
    go = 1'b1; cyc(1); go = 1'b0;
    chk("to_restart_ts", 32'(timerStart), 32'd1);
    chk("to_restart_rn", 32'(roundNum), 32'd1);
    chk("to_restart_sc", {24'd0, scoreA, scoreB}, 32'd0);

    // Async reset in the middle of the response window.
    start_done("ar", 2);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // Abort in WAIT_TIMER keeps the score; late timerDone ignored.
    go = 1'b1; cyc(1); go = 1'b0;
    cyc(1);
    press(1'b0, 1'b1);
    chk_score("ab_setup", 1, 1, 0);
    cyc(2);
    abort = 1'b1; cyc(1); abort = 1'b0;
    chk("ab_round", 32'(roundNum), 32'd0);
    chk("ab_active", 32'(roundActive), 32'd0);
    chk("ab_scoreA", 32'(scoreA), 32'd1);
    timerDone = 1'b1; cyc(1); timerDone = 1'b0;
    chk("ab_stray_done", 32'(roundActive), 32'd0);

    // Held button is not a press.
    btnA = 1'b1;
    cyc(1);
    go = 1'b1; cyc(1); go = 1'b0;
    start_done("held", 2);
    cyc(3);
    chk("held_no_win", 32'(winnerValid), 32'd0);
    btnA = 1'b0;
    press(1'b0, 1'b1);
    chk_score("held_b", 2, 0, 1);

    // Randomized traffic.
    td = 0;
    for (int i = 0; i < 4000; i++) begin
      if (timerStart) td = $urandom_range(1, 60);
      timerDone = 1'b0;
      if (td > 0) begin
        td--;
        if (td == 0) timerDone = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) timerDone = 1'b1;
      if ($urandom_range(0, 24) == 0) begin
        btnA = 1'b1;
        btnB = 1'b1;
      end else begin
        if ($urandom_range(0, 9) == 0) btnA = ~btnA;
        if ($urandom_range(0, 9) == 0) btnB = ~btnB;
      end
      go    = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    go = 1'b0; abort = 1'b0; btnA = 1'b0; btnB = 1'b0; timerDone = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/countdown_round_sequencer.md
Name: countdown_round_sequencer

Overview:
- Game-round controller that owns the countdown timer: launches each countdown, waits for its done pulse, then runs a timed response window and arbitrates two player buttons.
- Scores each round, advances a round counter, and reports game over after NUM_ROUNDS rounds.
- Sits between the player button synchronizers and the countdown timer, in the 100 MHz domain.

Parameters:
- NUM_ROUNDS, 3, rounds per game (1..15).
- RESP_WINDOW_CYC, 100000000, Clk100M cycles the response window stays open after timer done.
- TIMEOUT_CYC, 700000000, maximum cycles to wait for timerDone before flagging an error.

Ports:
- Clk100M  in  1  system clock, all logic on posedge.
- Reset  in  1  asynchronous, active-high reset.
- go  in  1  start a new game; sampled in IDLE, DONE and ERROR.
- abort  in  1  return to IDLE from any state.
- btnA  in  1  player A button, already synchronized, level.
- btnB  in  1  player B button, already synchronized, level.
- timerDone  in  1  one-cycle done pulse from the countdown timer.
- timerStart  out  1  one-cycle start pulse to the countdown timer.
- roundActive  out  1  high from START through RESPOND.
- roundNum  out  4  current round, 1-based; 0 in IDLE.
- winnerValid  out  1  one-cycle pulse in SCORE.
- winner  out  2  0 none, 1 A, 2 B, 3 double foul; valid with winnerValid, held until the next SCORE.
- scoreA  out  4  player A score, saturating.
- scoreB  out  4  player B score, saturating.
- gameOver  out  1  high in DONE.
- timeoutErr  out  1  high in ERROR.

Behaviour:
- Reset (async): state IDLE; all outputs 0; window/timeout counters 0; tie priority = A; button edge registers 0.
- Press = rising edge of btnX (registered previous value). Buttons already held on state entry do not count.
- IDLE: go=1 -> clear scores, roundNum=1, winner=0 -> START.
- START (1 cycle): timerStart=1; clear timeout counter -> WAIT_TIMER.
- WAIT_TIMER:
  - Priority: timerDone -> load window counter with RESP_WINDOW_CYC-1 -> RESPOND.
  - Else a press is a false start: only A -> winner=2; only B -> winner=1; both same cycle -> winner=3. Any false start -> SCORE.
  - Else timeout counter reaches TIMEOUT_CYC-1 -> ERROR.
  - timerDone and a press in the same cycle: timerDone wins and the press is ignored.
- RESPOND:
  - First press wins: A -> 1, B -> 2.
  - Same-cycle tie -> winner = current priority holder, then priority toggles.
  - Counter reaches 0 with no press -> winner=0.
  - Any of these -> SCORE.
  - Press on the expiry cycle counts.
- SCORE (1 cycle): winnerValid=1.
  - winner 1 -> scoreA+1; winner 2 -> scoreB+1; saturate at 15. Winners 0 and 3 score nothing.
  - roundNum==NUM_ROUNDS -> DONE; else roundNum+1 -> START.
- DONE: gameOver=1; scores and roundNum held; go -> same as IDLE go (new game, scores cleared).
- ERROR: timeoutErr=1; timerStart never asserted; go -> new game.
- abort (any state, highest priority below Reset): -> IDLE; roundNum=0; roundActive=0; scores held; pulses forced 0 that cycle. A timer mid-countdown finishes on its own; a stray timerDone in IDLE is ignored.
- Latency: go -> timerStart 1 cycle; timerDone -> RESPOND next cycle; deciding press -> winnerValid next cycle.
- Counter widths: $clog2 of the respective parameter, minimum 1.

Decomposition:
- Shared package: state enum (IDLE, START, WAIT_TIMER, RESPOND, SCORE, DONE, ERROR), winner encoding constants (WIN_NONE, WIN_A, WIN_B, WIN_FOUL2), score width 4.
- Sub-module: press_arbiter, holding edge detect for both buttons, same-cycle tie resolution and the round-robin priority flop. The FSM, counters and scores stay in the top level.

Test Plan:
- Bench parameters for all scenarios: NUM_ROUNDS=2, RESP_WINDOW_CYC=10, TIMEOUT_CYC=50.
- Nominal game: go; timerDone 5 cycles after timerStart; btnA rises 3 cycles later -> winnerValid with winner=1, scoreA=1. Round 2: B presses -> winner=2, scoreB=1, gameOver=1, roundNum=2.
- False starts: btnB rises in WAIT_TIMER -> winner=1, scoreA=1, timerDone never awaited. Next round, both rise in the same cycle -> winner=3, scores unchanged.
- Tie/window: simultaneous press in RESPOND twice -> winners 1 then 2 (priority toggles). No press for 10 cycles -> winner=0; a press on the 10th cycle instead -> counted.
- Timeout: timerDone withheld 50 cycles -> timeoutErr=1, roundActive=0. go -> scores 0, roundNum=1, timerStart pulse next cycle.
- Async reset and abort: assert Reset mid-RESPOND -> all outputs 0 immediately without a clock edge. abort in WAIT_TIMER with scoreA=1 -> IDLE, scoreA stays 1; late timerDone ignored; btnA held through entry to RESPOND not counted.
